blockram_port_arbiter: RTL and testbench
========================================

Name: blockram_port_arbiter

Overview:
Upstream stage for one port of the two-port block RAM. It multiplexes NumClients request channels onto a single RAM port with round-robin arbitration. It captures the RAM's same-cycle response and returns it to the issuing client through a per-client one-deep registered response slot. This gives each client an independent latency-1 request/response interface and isolates client backpressure from the RAM.

Parameters:
Name, "", instance label for debug output.
Width, 8, RAM word width.
AddrWidth, 8, RAM address width.
NumClients, 2, number of client channels (>=1).
CLog2NumClients, 1, max(1, ceil(log2(NumClients))).

Ports:
clk  input  1  clock.
resetn  input  1  reset.
client_reqs  input  NumClients*(Width+AddrWidth+1)  packed requests; client i occupies slice i.
client_req_valids  input  NumClients  request valid per client.
client_req_bps  output  NumClients  request backpressure per client.
client_resps  output  NumClients*Width  response data; client i occupies slice i.
client_resp_valids  output  NumClients  response valid per client.
client_resp_bps  input  NumClients  response backpressure per client.
mem_req  output  Width+AddrWidth+1  request to RAM port.
mem_req_valid  output  1  RAM request valid.
mem_req_bp  input  1  RAM request backpressure.
mem_resp  input  Width  RAM response data, same cycle as request.
mem_resp_valid  input  1  RAM response valid.
mem_resp_bp  output  1  backpressure to RAM response.

Behaviour:
- Interface: reset resetn, synchronous, active-low; clock clk.
- Request word layout: bit 0 is wr; bits [Width:1] are data; bits [Width+AddrWidth:Width+1] are addr. The arbiter passes the word through unmodified.
- Slot free(i): slot i is empty, or it holds valid data and client_resp_bps[i]=0 this cycle.
- Eligibility: eligible(i) = client_req_valids[i] & free(i).
- Round-robin search: search starts at (last_grant+1) mod NumClients and wraps; grant = first eligible index found. has_grant = at least one eligible client.
- mem_req = client_reqs slice of the granted client.
- mem_req_valid = has_grant.
- mem_resp_bp = ~has_grant.
- fire = has_grant & ~mem_req_bp & mem_resp_valid. When mem_req_bp=1, nothing fires and no state changes.
- client_req_bps[i] = ~(fire & grant==i). This is combinational. A non-granted valid client sees bp=1.
- On fire:
  - the granted slot loads mem_resp and its valid is set at the next edge;
  - last_grant <= grant.
- Slot i update at each edge, otherwise:
  - if valid & ~client_resp_bps[i], valid clears;
  - a simultaneous drain and load leaves valid set with the new data.
- Latency: request accepted at edge T; response visible at client from cycle T+1. Aggregate throughput is 1 request/cycle. Per-client throughput is 1/cycle while that client's resp_bp=0.
- Write responses: returned like reads; data equals the RAM contents before the write, since the RAM reads combinationally. Every accepted request produces exactly one response.
- Ordering: per client, responses are delivered in request order (slot depth 1 guarantees this). No ordering exists across clients.
- Fairness: a continuously eligible client waits at most NumClients-1 grants.
- Starvation: a client whose slot stays full is masked; it does not block other clients.
- Reset values:
  - all client_resp_valids = 0;
  - last_grant = NumClients-1, so client 0 has first priority;
  - slot data = x.
- Outputs during reset are derived combinationally from the reset state.
- Reset mid-operation: in-flight slot contents are discarded and no response is produced. A RAM write that fired in the same cycle as reset assertion still happens, because the RAM gates on its own reset.
- NumClients=1: degenerates to a pass-through with a single response register.
- Under verilator, each fire calls $c debug with Name, grant index and the request word.

Decomposition:
- Package llpm_mem_pkg holds:
  - localparam functions for request field offsets (wr bit, data lo/hi, addr lo/hi) and ReqWidth = Width+AddrWidth+1;
  - clog2 helper.
- Sub-module resp_slot: one-deep registered valid/data stage with load, drain and bp. It is instantiated NumClients times.
- Arbiter logic stays in the top module.

Test Plan:
- Reset, then client 0 writes addr 0x05 data 0xA5 (wr=1) -> mem_req = {0x05,0xA5,1} that cycle; client_resp_valids[0]=1 next cycle. Then a client 1 read of 0x05 -> resp 0xA5.
- Both clients valid every cycle, resp_bps=0 -> grants alternate 0,1,0,1 starting with 0; one fire per cycle.
- Client 0 resp_bp held 1 with slot full, client 0 and client 1 valid -> client 0 masked (req_bp=1), client 1 granted every cycle. Releasing bp -> client 0 slot drains and is re-granted in the same cycle.
- mem_req_bp=1 for 3 cycles with client 0 valid -> no fire, client_req_bps[0]=1, last_grant unchanged. On release, fire occurs and response appears 1 cycle later.
- Write 0x3C to addr 0x10 after 0x11 stored there -> write response data 0x11; a subsequent read returns 0x3C.
- Assert resetn=0 while both slots are valid -> both client_resp_valids are 0 after the edge, and the next grant goes to client 0.

Source files
------------

// File: rtl/llpm_mem_pkg.sv
// Shared helpers for the block RAM front-end: request word field offsets
// and a constant-time clog2 for sizing index fields.
package llpm_mem_pkg;

    function automatic int req_width(input int width, input int addr_width);
        return width + addr_width + 32'sd1;
    endfunction

    function automatic int req_wr_bit();
        return 32'sd0;
    endfunction

    function automatic int req_data_lo();
        return 32'sd1;
    endfunction

    function automatic int req_data_hi(input int width);
        return width;
    endfunction

    function automatic int req_addr_lo(input int width);
        return width + 32'sd1;
    endfunction

    function automatic int req_addr_hi(input int width, input int addr_width);
        return width + addr_width;
    endfunction

    // Returns at least 1 so a single-entry index still has a bit to live in.
    function automatic int clog2(input int n);
        int bits;
        bits = 32'sd0;
        while ((32'sd1 << bits) < n) begin
            bits = bits + 32'sd1;
        end
        return (bits < 32'sd1) ? 32'sd1 : bits;
    endfunction

endpackage

// File: rtl/blockram_port_arbiter_resp_slot.sv
// One-deep registered response stage: holds one RAM response until the
// client accepts it; reports whether it can take a new one this cycle.
module resp_slot #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [Width-1:0] load_data,
    input  logic             bp,
    output logic             valid,
    output logic [Width-1:0] data,
    output logic             free
);

    logic             valid_r;
    logic [Width-1:0] data_r;

    // Occupancy: a load wins over a drain so a same-cycle swap stays valid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
        end else if (!bp) begin
            valid_r <= 1'b0;
        end
    end

    // Payload carries no reset; it is only meaningful while valid_r is set.
    always_ff @(posedge clk) begin
        if (load) begin
            data_r <= load_data;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign free  = ~valid_r | ~bp;

endmodule

// File: rtl/blockram_port_arbiter.sv
// Round-robin front-end for one block RAM port: grants one client per cycle
// and returns the same-cycle RAM response through a per-client slot.
module blockram_port_arbiter
    import llpm_mem_pkg::*;
#(
    parameter string Name            = "",
    parameter int    Width           = 8,
    parameter int    AddrWidth       = 8,
    parameter int    NumClients      = 2,
    parameter int    CLog2NumClients = 1
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    input  logic [NumClients*(Width+AddrWidth+1)-1:0]   client_reqs,
    input  logic [NumClients-1:0]                       client_req_valids,
    output logic [NumClients-1:0]                       client_req_bps,
    output logic [NumClients*Width-1:0]                 client_resps,
    output logic [NumClients-1:0]                       client_resp_valids,
    input  logic [NumClients-1:0]                       client_resp_bps,
    output logic [Width+AddrWidth:0]                    mem_req,
    output logic                                        mem_req_valid,
    input  logic                                        mem_req_bp,
    input  logic [Width-1:0]                            mem_resp,
    input  logic                                        mem_resp_valid,
    output logic                                        mem_resp_bp
);

    localparam int ReqW = req_width(Width, AddrWidth);

    logic [NumClients-1:0]      slot_free_s;
    logic [NumClients-1:0]      eligible_s;
    logic [NumClients-1:0]      upper_s;
    logic [NumClients-1:0]      pool_s;
    logic [NumClients-1:0]      load_s;
    logic [CLog2NumClients-1:0] last_grant_r;
    logic [CLog2NumClients-1:0] grant_s;
    logic                       has_grant_s;
    logic                       fire_s;

    assign eligible_s = client_req_valids & slot_free_s;

    // Clients after the last grant get first pick.
    always_comb begin
        upper_s = '0;
        for (int i = 0; i < NumClients; i++) begin
            upper_s[i] = eligible_s[i] && (i > int'(last_grant_r));
        end
    end

    // Lowest index in the preferred pool wins; fall back to wrapping from 0.
    always_comb begin
        pool_s      = (|upper_s) ? upper_s : eligible_s;
        has_grant_s = |eligible_s;
        grant_s     = '0;
        for (int i = NumClients - 1; i >= 0; i--) begin
            grant_s = pool_s[i] ? CLog2NumClients'(i) : grant_s;
        end
    end

    // Route the granted request word to the RAM unchanged.
    always_comb begin
        mem_req = '0;
        for (int i = 0; i < NumClients; i++) begin
            mem_req = (grant_s == CLog2NumClients'(i)) ? client_reqs[i*ReqW +: ReqW] : mem_req;
        end
    end

    assign fire_s        = has_grant_s & ~mem_req_bp & mem_resp_valid;
    assign mem_req_valid = has_grant_s;
    assign mem_resp_bp   = ~has_grant_s;

    // One-hot acceptance strobe; doubles as the slot load enable.
    always_comb begin
        load_s = '0;
        for (int i = 0; i < NumClients; i++) begin
            load_s[i] = fire_s && (grant_s == CLog2NumClients'(i));
        end
    end

    assign client_req_bps = ~load_s;

    // Reset value makes client 0 the first winner.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant_r <= CLog2NumClients'(NumClients - 1);
        end else if (fire_s) begin
            last_grant_r <= grant_s;
        end
    end

    for (genvar g = 0; g < NumClients; g++) begin : g_slot
        resp_slot #(
            .Width(Width)
        ) u_slot (
            .clk       (clk),
            .resetn    (resetn),
            .load      (load_s[g]),
            .load_data (mem_resp),
            .bp        (client_resp_bps[g]),
            .valid     (client_resp_valids[g]),
            .data      (client_resps[g*Width +: Width]),
            .free      (slot_free_s[g])
        );
    end

    // Simulation trace of every accepted request.
    always_ff @(posedge clk) begin
        if (resetn && fire_s) begin
            $display("blockram_port_arbiter %s grant=%0d req=0x%0h", Name, grant_s, mem_req);
        end
    end

endmodule

// File: tb/tb_blockram_port_arbiter.sv
// Directed table-driven bench for blockram_port_arbiter with two clients and
// a small combinational RAM model behind the port.
module tb_blockram_port_arbiter;

    localparam int W  = 8;
    localparam int A  = 8;
    localparam int N  = 2;
    localparam int RW = W + A + 1;
    localparam int NV = 19;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N*RW-1:0]   client_reqs;
    logic [N-1:0]      client_req_valids;
    logic [N-1:0]      client_req_bps;
    logic [N*W-1:0]    client_resps;
    logic [N-1:0]      client_resp_valids;
    logic [N-1:0]      client_resp_bps;
    logic [RW-1:0]     mem_req;
    logic              mem_req_valid;
    logic              mem_req_bp;
    logic [W-1:0]      mem_resp;
    logic              mem_resp_valid;
    logic              mem_resp_bp;

    logic [7:0] ram [256] = '{default: 8'h00};

    int checks   = 0;
    int failures = 0;

    blockram_port_arbiter #(
        .Name            ("tb"),
        .Width           (W),
        .AddrWidth       (A),
        .NumClients      (N),
        .CLog2NumClients (1)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .client_reqs        (client_reqs),
        .client_req_valids  (client_req_valids),
        .client_req_bps     (client_req_bps),
        .client_resps       (client_resps),
        .client_resp_valids (client_resp_valids),
        .client_resp_bps    (client_resp_bps),
        .mem_req            (mem_req),
        .mem_req_valid      (mem_req_valid),
        .mem_req_bp         (mem_req_bp),
        .mem_resp           (mem_resp),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_bp        (mem_resp_bp)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, write on an accepted write request.
    assign mem_resp = ram[mem_req[16:9]];
    always @(posedge clk) begin
        if (mem_req_valid && !mem_req_bp && mem_resp_valid && mem_req[0]) begin
            ram[mem_req[16:9]] <= mem_req[8:1];
        end
    end

    typedef struct {
        logic [1:0]  rv;
        logic [16:0] w0;
        logic [16:0] w1;
        logic [1:0]  rbp;
        logic        mbp;
        logic        mvalid;
        logic [16:0] mreq;
        logic [1:0]  rbps;
        logic [1:0]  rvout;
        logic [7:0]  d0;
        logic [7:0]  d1;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [16:0] mk(input logic [7:0] a, input logic [7:0] d, input logic w);
        return {a, d, w};
    endfunction

    function automatic vec_t vrow(input logic [1:0] rv, input logic [16:0] w0, input logic [16:0] w1,
                                  input logic [1:0] rbp, input logic mbp, input logic mvalid,
                                  input logic [16:0] mreq, input logic [1:0] rbps, input logic [1:0] rvout,
                                  input logic [7:0] d0, input logic [7:0] d1);
        vec_t v;
        v.rv = rv; v.w0 = w0; v.w1 = w1; v.rbp = rbp; v.mbp = mbp; v.mvalid = mvalid;
        v.mreq = mreq; v.rbps = rbps; v.rvout = rvout; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    logic [16:0] rd0;
    logic [16:0] rd1;

    initial begin
        rd0 = mk(8'h05, 8'h00, 1'b0);
        rd1 = mk(8'h05, 8'h77, 1'b0);

        vecs[0]  = vrow(2'b01, mk(8'h05, 8'hA5, 1'b1), 17'h0, 2'b00, 1'b0, 1'b1, mk(8'h05, 8'hA5, 1'b1), 2'b10, 2'b01, 8'h00, 8'h00);
        vecs[1]  = vrow(2'b10, 17'h0, rd0, 2'b00, 1'b0, 1'b1, rd0, 2'b01, 2'b10, 8'h00, 8'hA5);
        vecs[2]  = vrow(2'b11, rd0, rd1, 2'b00, 1'b0, 1'b1, rd0, 2'b10, 2'b01, 8'hA5, 8'h00);
        vecs[3]  = vrow(2'b11, rd0, rd1, 2'b00, 1'b0, 1'b1, rd1, 2'b01, 2'b10, 8'h00, 8'hA5);
        vecs[4]  = vrow(2'b11, rd0, rd1, 2'b00, 1'b0, 1'b1, rd0, 2'b10, 2'b01, 8'hA5, 8'h00);
        vecs[5]  = vrow(2'b11, rd0, rd1, 2'b00, 1'b0, 1'b1, rd1, 2'b01, 2'b10, 8'h00, 8'hA5);
        vecs[6]  = vrow(2'b11, rd0, rd1, 2'b01, 1'b0, 1'b1, rd0, 2'b10, 2'b01, 8'hA5, 8'h00);
        vecs[7]  = vrow(2'b11, rd0, rd1, 2'b01, 1'b0, 1'b1, rd1, 2'b01, 2'b11, 8'hA5, 8'hA5);
        vecs[8]  = vrow(2'b11, rd0, rd1, 2'b01, 1'b0, 1'b1, rd1, 2'b01, 2'b11, 8'hA5, 8'hA5);
        vecs[9]  = vrow(2'b11, rd0, rd1, 2'b00, 1'b0, 1'b1, rd0, 2'b10, 2'b01, 8'hA5, 8'h00);
        vecs[10] = vrow(2'b01, rd0, 17'h0, 2'b00, 1'b1, 1'b1, rd0, 2'b11, 2'b00, 8'h00, 8'h00);
        vecs[11] = vrow(2'b01, rd0, 17'h0, 2'b00, 1'b1, 1'b1, rd0, 2'b11, 2'b00, 8'h00, 8'h00);
        vecs[12] = vrow(2'b01, rd0, 17'h0, 2'b00, 1'b1, 1'b1, rd0, 2'b11, 2'b00, 8'h00, 8'h00);
        vecs[13] = vrow(2'b01, rd0, 17'h0, 2'b00, 1'b0, 1'b1, rd0, 2'b10, 2'b01, 8'hA5, 8'h00);
        vecs[14] = vrow(2'b00, 17'h0, 17'h0, 2'b00, 1'b0, 1'b0, 17'h0, 2'b11, 2'b00, 8'h00, 8'h00);
        vecs[15] = vrow(2'b10, 17'h0, mk(8'h10, 8'h11, 1'b1), 2'b00, 1'b0, 1'b1, mk(8'h10, 8'h11, 1'b1), 2'b01, 2'b10, 8'h00, 8'h00);
        vecs[16] = vrow(2'b01, mk(8'h10, 8'h3C, 1'b1), 17'h0, 2'b00, 1'b0, 1'b1, mk(8'h10, 8'h3C, 1'b1), 2'b10, 2'b01, 8'h11, 8'h00);
        vecs[17] = vrow(2'b10, 17'h0, mk(8'h10, 8'h00, 1'b0), 2'b00, 1'b0, 1'b1, mk(8'h10, 8'h00, 1'b0), 2'b01, 2'b10, 8'h00, 8'h3C);
        vecs[18] = vrow(2'b11, rd0, rd1, 2'b11, 1'b0, 1'b1, rd0, 2'b10, 2'b11, 8'hA5, 8'h3C);

        resetn            = 1'b0;
        client_reqs       = '0;
        client_req_valids = '0;
        client_resp_bps   = '0;
        mem_req_bp        = 1'b0;
        mem_resp_valid    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_resp_valids", 32'(client_resp_valids), 32'h0);
        check("reset_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check("reset_mem_resp_bp", 32'(mem_resp_bp), 32'h1);
        check("reset_req_bps", 32'(client_req_bps), 32'h3);

        @(negedge clk);
        resetn = 1'b1;

        for (int r = 0; r < NV; r++) begin
            @(negedge clk);
            client_req_valids = vecs[r].rv;
            client_reqs       = {vecs[r].w1, vecs[r].w0};
            client_resp_bps   = vecs[r].rbp;
            mem_req_bp        = vecs[r].mbp;
            #1;
            check($sformatf("row%0d_mem_req_valid", r), 32'(mem_req_valid), 32'(vecs[r].mvalid));
            check($sformatf("row%0d_mem_resp_bp", r), 32'(mem_resp_bp), 32'(!vecs[r].mvalid));
            if (vecs[r].mvalid) begin
                check($sformatf("row%0d_mem_req", r), 32'(mem_req), 32'(vecs[r].mreq));
            end
            check($sformatf("row%0d_req_bps", r), 32'(client_req_bps), 32'(vecs[r].rbps));
            @(posedge clk);
            #1;
            check($sformatf("row%0d_resp_valids", r), 32'(client_resp_valids), 32'(vecs[r].rvout));
            if (vecs[r].rvout[0]) begin
                check($sformatf("row%0d_resp0", r), 32'(client_resps[7:0]), 32'(vecs[r].d0));
            end
            if (vecs[r].rvout[1]) begin
                check($sformatf("row%0d_resp1", r), 32'(client_resps[15:8]), 32'(vecs[r].d1));
            end
        end

        // Reset while both slots hold data: contents drop, client 0 regains priority.
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_resp_valids", 32'(client_resp_valids), 32'h0);
        check("midreset_req_bps", 32'(client_req_bps), 32'h2);

        @(negedge clk);
        resetn          = 1'b1;
        client_resp_bps = 2'b00;
        #1;
        check("postreset_req_bps", 32'(client_req_bps), 32'h2);
        check("postreset_mem_req", 32'(mem_req), 32'(rd0));
        @(posedge clk);
        #1;
        check("postreset_resp_valids", 32'(client_resp_valids), 32'h1);
        check("postreset_resp0", 32'(client_resps[7:0]), 32'hA5);

        @(negedge clk);
        client_req_valids = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
